// File: rtl/heard_packetizer_pkg.sv
// Shared types for heard_packetizer: packet magic, output FSM states and the FIFO entry layout.
// HEARD_PACKETIZER_PARITY_EN adds a stored even-parity bit to each entry.
package heard_packetizer_pkg;

    localparam logic [7:0] PKT_MAGIC = 8'hA5;

    typedef enum logic [1:0] {IDLE, HDR, PAY} pkt_state_e;

    // seq is always 16 bits wide; narrower counters are zero-extended at push
    typedef struct packed {
        logic [3:0]  lane;
        logic [15:0] seq;
`ifdef HEARD_PACKETIZER_PARITY_EN
        logic        par;
`endif
        logic [31:0] v;
    } entry_t;

    function automatic logic [31:0] make_header(input entry_t e);
        logic p;
`ifdef HEARD_PACKETIZER_PARITY_EN
        p = e.par;
`else
        p = 1'b0;
`endif
        return {PKT_MAGIC, e.lane, p, 3'b000, e.seq};
    endfunction

endpackage

// File: rtl/heard_fifo.sv
// Synchronous power-of-two entry FIFO with full/empty/count and a one-ahead peek port,
// so the packet FSM can chain headers without an idle cycle.
module heard_fifo
    import heard_packetizer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     push,
    input  entry_t                   wdata,
    input  logic                     pop,
    output entry_t                   head,
    output entry_t                   head_next,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     cnt;
    logic            do_push;
    logic            do_pop;

    assign full    = (cnt == (AW + 1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head      = mem[rd_ptr];
    assign head_next = mem[rd_ptr + AW'(1)];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW + 1)'(1);
                2'b01:   cnt <= cnt - (AW + 1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/heard_packetizer.sv
// Stamps heard() responses with per-lane sequence numbers and serialises them as header/payload
// beats. Optional header parity bit under HEARD_PACKETIZER_PARITY_EN.
module heard_packetizer
    import heard_packetizer_pkg::*;
#(
    parameter int unsigned LANES = 10,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned SEQ_W = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        heard__ENA,
    input  logic [3:0]  heard_meth,
    input  logic [31:0] heard_v,
    output logic        heard__RDY,
    output logic        pkt__ENA,
    output logic [31:0] pkt_data,
    output logic        pkt_last,
    input  logic        pkt__RDY,
    output logic        err_lane
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    pkt_state_e       state;
    logic             up_q;
    logic [SEQ_W-1:0] seq_q [LANES];
    logic             accept;
    logic             lane_ok;
    logic             push;
    logic             pop;
    entry_t           wdata;
    entry_t           head;
    entry_t           head_next;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;

    assign accept     = heard__ENA && heard__RDY;
    assign lane_ok    = 32'(heard_meth) < LANES;
    assign push       = accept && lane_ok;
    assign pop        = (state == PAY) && pkt__RDY;
    assign heard__RDY = up_q && !full;

    always_comb begin
        wdata      = '0;
        wdata.lane = heard_meth;
        wdata.seq  = 16'(seq_q[heard_meth]);
        wdata.v    = heard_v;
`ifdef HEARD_PACKETIZER_PARITY_EN
        wdata.par  = ^heard_v;
`endif
    end

    heard_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (push),
        .wdata     (wdata),
        .pop       (pop),
        .head      (head),
        .head_next (head_next),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // Holds RDY low during reset and for the first cycle after it
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) up_q <= 1'b0;
        else     up_q <= 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < int'(LANES); i++) seq_q[i] <= '0;
        end else if (push) begin
            seq_q[heard_meth] <= seq_q[heard_meth] + SEQ_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                    err_lane <= 1'b0;
        else if (accept && !lane_ok) err_lane <= 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            pkt__ENA <= 1'b0;
            pkt_data <= '0;
            pkt_last <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!empty) begin
                        state    <= HDR;
                        pkt__ENA <= 1'b1;
                        pkt_data <= make_header(head);
                        pkt_last <= 1'b0;
                    end
                end
                HDR: begin
                    if (pkt__RDY) begin
                        state    <= PAY;
                        pkt_data <= head.v;
                        pkt_last <= 1'b1;
                    end
                end
                PAY: begin
                    if (pkt__RDY) begin
                        // head is popped this edge, so the follower is at head_next
                        if (count > CW'(1)) begin
                            state    <= HDR;
                            pkt_data <= make_header(head_next);
                            pkt_last <= 1'b0;
                        end else begin
                            state    <= IDLE;
                            pkt__ENA <= 1'b0;
                            pkt_data <= '0;
                            pkt_last <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_heard_packetizer.sv
// Directed self-checking bench for heard_packetizer (SEQ_W=4) with a beat scoreboard.
module tb_heard_packetizer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        heard__ENA = 1'b0;
    logic [3:0]  heard_meth = '0;
    logic [31:0] heard_v = '0;
    logic        heard__RDY;
    logic        pkt__ENA;
    logic [31:0] pkt_data;
    logic        pkt_last;
    logic        pkt__RDY = 1'b0;
    logic        err_lane;

    heard_packetizer #(
        .LANES (10),
        .DEPTH (4),
        .SEQ_W (4)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .heard__ENA (heard__ENA),
        .heard_meth (heard_meth),
        .heard_v    (heard_v),
        .heard__RDY (heard__RDY),
        .pkt__ENA   (pkt__ENA),
        .pkt_data   (pkt_data),
        .pkt_last   (pkt_last),
        .pkt__RDY   (pkt__RDY),
        .err_lane   (err_lane)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_fail = 0;
    int    exp_seq[16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] hdr(input logic [3:0] lane, input int seq,
                                        input logic [31:0] v);
        logic p;
        p = 1'b0;
`ifdef HEARD_PACKETIZER_PARITY_EN
        p = ^v;
`endif
        return {8'hA5, lane, p, 3'b000, 16'(seq)};
    endfunction

    // Starts and ends at posedge+1; accepted valid-lane responses enqueue two beats
    task automatic send(input logic [3:0] lane, input logic [31:0] v, input bit exp_acc);
        heard__ENA = 1'b1;
        heard_meth = lane;
        heard_v    = v;
        @(negedge CLK);
        check("heard_rdy", 32'(heard__RDY), 32'(exp_acc));
        if (exp_acc && lane < 4'd10) begin
            exp_q.push_back({1'b0, hdr(lane, exp_seq[lane], v)});
            exp_q.push_back({1'b1, v});
            exp_seq[lane] = (exp_seq[lane] + 1) % 16;
        end
        @(posedge CLK);
        #1;
        heard__ENA = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge CLK);
            #1;
            k++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Beat monitor: a transfer happens at the next posedge iff ENA && RDY now
    always @(negedge CLK) begin
        beat_t b;
        if (!RST && pkt__ENA && pkt__RDY) begin
            check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                b = exp_q.pop_front();
                check("beat_data", pkt_data, b.data);
                check("beat_last", 32'(pkt_last), 32'(b.last));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) exp_seq[i] = 0;

        // Reset values
        @(negedge CLK);
        check("rst_pkt_ena", 32'(pkt__ENA), 32'd0);
        check("rst_pkt_data", pkt_data, 32'd0);
        check("rst_pkt_last", 32'(pkt_last), 32'd0);
        check("rst_err_lane", 32'(err_lane), 32'd0);
        check("rst_heard_rdy", 32'(heard__RDY), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check("rdy_after_rst", 32'(heard__RDY), 32'd0);
        @(negedge CLK);
        check("rdy_one_cycle_later", 32'(heard__RDY), 32'd1);
        @(posedge CLK);
        #1;

        // Single response with exact latency
        pkt__RDY = 1'b1;
        send(4'd3, 32'hDEADBEEF, 1'b1);
        @(negedge CLK);
        check("lat_n1_idle", 32'(pkt__ENA), 32'd0);
        @(negedge CLK);
        check("lat_n2_ena", 32'(pkt__ENA), 32'd1);
        check("lat_n2_hdr", pkt_data, 32'hA530_0000);
        @(negedge CLK);
        check("lat_n3_pay", pkt_data, 32'hDEADBEEF);
        check("lat_n3_last", 32'(pkt_last), 32'd1);
        @(posedge CLK);
        #1;
        drain(10);

        // Sequence wrap on lane 0 with lane 1 interleaved
        for (int i = 0; i < 21; i++) begin
            send((i % 5 == 4) ? 4'd1 : 4'd0, 32'h1000_0000 + 32'(i), 1'b1);
            cycles(1);
        end
        drain(60);
        check("lane0_seq_wrapped", 32'(exp_seq[0]), 32'd1);

        // Back-pressure: four fit, fifth is refused, beats held while stalled
        pkt__RDY = 1'b0;
        send(4'd2, 32'hA000_0001, 1'b1);
        send(4'd2, 32'hA000_0002, 1'b1);
        send(4'd5, 32'hA000_0003, 1'b1);
        send(4'd2, 32'hA000_0004, 1'b1);
        send(4'd6, 32'hA000_0005, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("stall_ena", 32'(pkt__ENA), 32'd1);
            check("stall_data", pkt_data, exp_q[0].data);
        end
        @(posedge CLK);
        #1;
        check("stall_queued_beats", 32'(exp_q.size()), 32'd8);
        pkt__RDY = 1'b1;
        drain(30);

        // Bad lane: dropped, sticky error, counters untouched
        send(4'd12, 32'hBAD0_BAD0, 1'b1);
        check("err_lane_set", 32'(err_lane), 32'd1);
        cycles(3);
        check("bad_lane_no_pkt", 32'(pkt__ENA), 32'd0);
        send(4'd3, 32'h0000_0001, 1'b1);
        send(4'd4, 32'h0000_0003, 1'b1);
        drain(20);
        check("err_lane_sticky", 32'(err_lane), 32'd1);

        // Reset while a payload beat is stalled
        pkt__RDY = 1'b0;
        send(4'd7, 32'h1234_5678, 1'b1);
        cycles(1);
        pkt__RDY = 1'b1;
        cycles(1);
        pkt__RDY = 1'b0;
        @(negedge CLK);
        check("in_pay_last", 32'(pkt_last), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        check("rst_async_ena", 32'(pkt__ENA), 32'd0);
        check("rst_abandon_pay", 32'(exp_q.size()), 32'd1);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_seq[i] = 0;
        check("rst_rdy_low", 32'(heard__RDY), 32'd0);
        check("rst_err_clear", 32'(err_lane), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        pkt__RDY = 1'b1;
        cycles(2);
        check("post_rst_idle", 32'(pkt__ENA), 32'd0);
        send(4'd3, 32'h0BAD_F00D, 1'b1);
        drain(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
